// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, the
// end-of-program word, execution-mode codes and the byte-lane count.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_WAIT_MODE = 3'd1,
        ST_WAIT_GO   = 3'd2,
        ST_RUN_CONT  = 3'd3,
        ST_RUN_STEP  = 3'd4,
        ST_FINISHED  = 3'd5
    } state_t;

    // All-ones word doubles as the CPU HALT encoding.
    localparam logic [31:0] TERM_WORD = 32'hFFFF_FFFF;

    localparam logic MODE_CONT = 1'b0;
    localparam logic MODE_STEP = 1'b1;

    localparam int unsigned LANES = 4;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Byte-to-word assembler. Bytes land in lanes LSB first (lane 0 = bits
// N_BITS-1:0). word_last flags the byte that completes a word, and
// word_next is the completed word including that byte, both in the same
// cycle, so a caller can register the write without an extra cycle.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   enable       accept bytes only while high
//   byte_data    incoming byte
//   byte_valid   one-cycle strobe for byte_data
//   word_next    lanes with the current byte merged in
//   word_last    current byte completes a word (pulse)
module program_loader_word_assembler #(
    parameter int unsigned N_BITS = 8,
    parameter int unsigned LANES  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [N_BITS-1:0]         byte_data,
    input  logic                      byte_valid,
    output logic [LANES*N_BITS-1:0]   word_next,
    output logic                      word_last
);

    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES*N_BITS-1:0] lanes;
    logic [IDX_W-1:0]        idx;

    always_comb begin
        word_next = lanes;
        word_next[idx*N_BITS +: N_BITS] = byte_data;
        word_last = enable && byte_valid && (idx == IDX_W'(LANES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes <= '0;
            idx   <= '0;
        end else if (enable && byte_valid) begin
            lanes <= word_next;
            idx   <= word_last ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Debug-unit program loader. Reassembles UART bytes into instructions,
// writes them to instruction memory until the terminator word, then takes
// an execution-mode byte and drives CPU enable / single-step until halt.
//
// Ports:
//   i_clk, i_reset   clock, async active-low reset
//   i_rx_data        received byte, valid while i_rx_done=1
//   i_rx_done        one-cycle strobe per received byte
//   i_halt           CPU has retired HALT (level)
//   o_imem_we        instruction-memory write strobe
//   o_imem_addr      word address of the write
//   o_imem_data      assembled instruction
//   o_enable         CPU clock-enable (continuous mode)
//   o_step           single-step pulse
//   o_mode_step      latched mode, 1 = step
//   o_load_done      program fully loaded
//   o_overflow       sticky: word arrived with memory full
//   o_done           pulse when execution ends
//
// state      | meaning
// -----------+------------------------------------------------------
// LOAD       | assembling bytes into words and writing memory
// WAIT_MODE  | next byte bit0 selects step (1) or continuous (0)
// WAIT_GO    | next byte starts continuous execution
// RUN_CONT   | o_enable held high until halt
// RUN_STEP   | byte with bit0=1 issues one step pulse, until halt
// FINISHED   | execution ended; only reset leaves
module program_loader #(
    parameter int unsigned N_BITS = 8,
    parameter int unsigned INST_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter logic [INST_W-1:0] TERM_WORD = program_loader_pkg::TERM_WORD
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N_BITS-1:0] i_rx_data,
    input  logic              i_rx_done,
    input  logic              i_halt,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [INST_W-1:0] o_imem_data,
    output logic              o_enable,
    output logic              o_step,
    output logic              o_mode_step,
    output logic              o_load_done,
    output logic              o_overflow,
    output logic              o_done
);

    import program_loader_pkg::*;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   wr_ptr, wr_ptr_nx;
    logic                full, full_nx;
    logic                we_nx, enable_nx, step_nx, mode_nx;
    logic                load_done_nx, overflow_nx, done_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [INST_W-1:0]   data_nx;
    logic [INST_W-1:0]   word_next;
    logic                word_last;
    logic                is_term;

    program_loader_word_assembler #(
        .N_BITS (N_BITS),
        .LANES  (LANES)
    ) u_asm (
        .clk        (i_clk),
        .rst_n      (i_reset),
        .enable     (state == ST_LOAD),
        .byte_data  (i_rx_data),
        .byte_valid (i_rx_done),
        .word_next  (word_next),
        .word_last  (word_last)
    );

    assign is_term = (word_next == TERM_WORD);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_LOAD;
            wr_ptr      <= '0;
            full        <= 1'b0;
            o_imem_we   <= 1'b0;
            o_imem_addr <= '0;
            o_imem_data <= '0;
            o_enable    <= 1'b0;
            o_step      <= 1'b0;
            o_mode_step <= 1'b0;
            o_load_done <= 1'b0;
            o_overflow  <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state       <= state_nx;
            wr_ptr      <= wr_ptr_nx;
            full        <= full_nx;
            o_imem_we   <= we_nx;
            o_imem_addr <= addr_nx;
            o_imem_data <= data_nx;
            o_enable    <= enable_nx;
            o_step      <= step_nx;
            o_mode_step <= mode_nx;
            o_load_done <= load_done_nx;
            o_overflow  <= overflow_nx;
            o_done      <= done_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        wr_ptr_nx    = wr_ptr;
        full_nx      = full;
        we_nx        = 1'b0;
        addr_nx      = o_imem_addr;
        data_nx      = o_imem_data;
        step_nx      = 1'b0;
        done_nx      = 1'b0;
        mode_nx      = o_mode_step;
        load_done_nx = o_load_done;
        overflow_nx  = o_overflow;

        case (state)
            ST_LOAD: begin
                if (word_last) begin
                    if (!full) begin
                        we_nx   = 1'b1;
                        addr_nx = wr_ptr;
                        data_nx = word_next;
                        // Pointer parks on the last slot; full blocks later writes.
                        if (wr_ptr == '1) full_nx = 1'b1;
                        else              wr_ptr_nx = wr_ptr + 1'b1;
                    end else if (!is_term) begin
                        overflow_nx = 1'b1;
                    end
                    if (is_term) begin
                        load_done_nx = 1'b1;
                        state_nx     = ST_WAIT_MODE;
                    end
                end
            end
            ST_WAIT_MODE: begin
                if (i_rx_done) begin
                    mode_nx  = i_rx_data[0];
                    state_nx = (i_rx_data[0] == MODE_STEP) ? ST_RUN_STEP : ST_WAIT_GO;
                end
            end
            ST_WAIT_GO: begin
                if (i_rx_done) state_nx = ST_RUN_CONT;
            end
            ST_RUN_CONT: begin
                if (i_halt) begin
                    state_nx = ST_FINISHED;
                    done_nx  = 1'b1;
                end
            end
            ST_RUN_STEP: begin
                // Halt wins over a byte arriving in the same cycle.
                if (i_halt) begin
                    state_nx = ST_FINISHED;
                    done_nx  = 1'b1;
                end else if (i_rx_done && i_rx_data[0]) begin
                    step_nx = 1'b1;
                end
            end
            default: begin
                state_nx = state;
            end
        endcase

        enable_nx = (state_nx == ST_RUN_CONT);
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam logic [31:0] TERM = 32'hFFFF_FFFF;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          at;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: default geometry. DUT B: 4-word memory for the full/overflow case.
    logic       rst_a, rx_done_a, halt_a;
    logic [7:0] rx_data_a;
    logic       we_a, enable_a, step_a, mode_a, ld_a, ovf_a, done_a;
    logic [7:0] addr_a;
    logic [31:0] data_a;

    logic       rst_b, rx_done_b, halt_b;
    logic [7:0] rx_data_b;
    logic       we_b, enable_b, step_b, mode_b, ld_b, ovf_b, done_b;
    logic [1:0] addr_b;
    logic [31:0] data_b;

    program_loader dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_rx_data(rx_data_a), .i_rx_done(rx_done_a),
        .i_halt(halt_a), .o_imem_we(we_a), .o_imem_addr(addr_a), .o_imem_data(data_a),
        .o_enable(enable_a), .o_step(step_a), .o_mode_step(mode_a),
        .o_load_done(ld_a), .o_overflow(ovf_a), .o_done(done_a)
    );

    program_loader #(.ADDR_W(2)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_rx_data(rx_data_b), .i_rx_done(rx_done_b),
        .i_halt(halt_b), .o_imem_we(we_b), .o_imem_addr(addr_b), .o_imem_data(data_b),
        .o_enable(enable_b), .o_step(step_b), .o_mode_step(mode_b),
        .o_load_done(ld_b), .o_overflow(ovf_b), .o_done(done_b)
    );

    int errors = 0;
    int checks = 0;

    wr_t exp_wr_a[$];
    wr_t exp_wr_b[$];
    int  exp_step[$];
    int  exp_done[$];

    // Reference model: word count per DUT, sticky flags.
    int waddr[2];
    bit exp_ovf[2];
    bit exp_ld[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon_a
        wr_t e;
        if (we_a) begin
            if (exp_wr_a.size() == 0) check("unexpected_write_a", 64'd1, 64'd0);
            else begin
                e = exp_wr_a.pop_front();
                check("wr_addr_a", 64'(addr_a), 64'(e.addr));
                check("wr_data_a", 64'(data_a), 64'(e.data));
                check("wr_latency_a", 64'(cyc), 64'(e.at));
            end
        end
        if (step_a) begin
            if (exp_step.size() == 0) check("unexpected_step", 64'd1, 64'd0);
            else check("step_cycle", 64'(cyc), 64'(exp_step.pop_front()));
        end
        if (done_a) begin
            if (exp_done.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else check("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
        end
    end

    always @(negedge clk) begin : mon_b
        wr_t e;
        if (we_b) begin
            if (exp_wr_b.size() == 0) check("unexpected_write_b", 64'd1, 64'd0);
            else begin
                e = exp_wr_b.pop_front();
                check("wr_addr_b", 64'(addr_b), 64'(e.addr));
                check("wr_data_b", 64'(data_b), 64'(e.data));
                check("wr_latency_b", 64'(cyc), 64'(e.at));
            end
        end
        if (done_b || step_b || enable_b) check("b_exec_activity", 64'd1, 64'd0);
    end

    task automatic set_rx(input bit sel, input logic [7:0] b, input logic d);
        if (sel) begin rx_data_b = b; rx_done_b = d; end
        else     begin rx_data_a = b; rx_done_a = d; end
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
        @(negedge clk); set_rx(sel, b, 1'b1);
        @(negedge clk); set_rx(sel, 8'h00, 1'b0);
        repeat (gap) @(negedge clk);
    endtask

    task automatic model_word(input bit sel, input logic [31:0] w, input int at);
        int  depth;
        wr_t e;
        depth = sel ? 4 : 256;
        if (waddr[sel] < depth) begin
            e.addr = 8'(waddr[sel]);
            e.data = w;
            e.at   = at;
            if (sel) exp_wr_b.push_back(e); else exp_wr_a.push_back(e);
            waddr[sel]++;
        end else if (w != TERM) begin
            exp_ovf[sel] = 1'b1;
        end
        if (w == TERM) exp_ld[sel] = 1'b1;
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w);
        for (int i = 0; i < 3; i++) send_byte(sel, w[8*i +: 8], $urandom_range(0, 3));
        @(negedge clk); set_rx(sel, w[31:24], 1'b1);
        model_word(sel, w, cyc + 1);
        @(negedge clk); set_rx(sel, 8'h00, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic check_status(input bit sel);
        if (sel) begin
            check("load_done_b", 64'(ld_b), 64'(exp_ld[1]));
            check("overflow_b", 64'(ovf_b), 64'(exp_ovf[1]));
        end else begin
            check("load_done_a", 64'(ld_a), 64'(exp_ld[0]));
            check("overflow_a", 64'(ovf_a), 64'(exp_ovf[0]));
        end
    endtask

    task automatic reset_dut(input bit sel);
        if (sel) check("pending_wr_b_at_reset", 64'(exp_wr_b.size()), 64'd0);
        else     check("pending_wr_a_at_reset", 64'(exp_wr_a.size()), 64'd0);
        @(negedge clk);
        if (sel) rst_b = 1'b0; else rst_a = 1'b0;
        waddr[sel] = 0; exp_ovf[sel] = 1'b0; exp_ld[sel] = 1'b0;
        @(negedge clk);
        if (sel) check("reset_outputs_b", 64'({we_b, addr_b, data_b, enable_b, step_b, mode_b, ld_b, ovf_b, done_b}), 64'd0);
        else     check("reset_outputs_a", 64'({we_a, addr_a, data_a, enable_a, step_a, mode_a, ld_a, ovf_a, done_a}), 64'd0);
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    endtask

    task automatic step_byte(input logic [7:0] b, input bit live);
        @(negedge clk); set_rx(1'b0, b, 1'b1);
        if (live && b[0]) exp_step.push_back(cyc + 1);
        @(negedge clk); set_rx(1'b0, 8'h00, 1'b0);
        check("enable_in_step", 64'(enable_a), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == TERM) w = 32'h0;
        return w;
    endfunction

    initial begin
        logic [7:0] r;
        rst_a = 1'b0; rst_b = 1'b0;
        rx_data_a = '0; rx_done_a = 1'b0; halt_a = 1'b0;
        rx_data_b = '0; rx_done_b = 1'b0; halt_b = 1'b0;
        repeat (2) @(negedge clk);
        reset_dut(1'b0);
        reset_dut(1'b1);

        // Partial word discarded by reset, then a fresh program.
        send_byte(1'b0, 8'hAA, 1);
        send_byte(1'b0, 8'h55, 1);
        reset_dut(1'b0);
        send_word(1'b0, 32'h2001_0005); check_status(1'b0);
        send_word(1'b0, 32'h0000_0000); check_status(1'b0);
        for (int i = 0; i < 4; i++) begin
            send_word(1'b0, rand_word());
            check_status(1'b0);
        end
        send_word(1'b0, TERM); check_status(1'b0);

        // Halt outside run states must be ignored.
        @(negedge clk); halt_a = 1'b1;
        @(negedge clk); halt_a = 1'b0;

        // Continuous mode.
        r = 8'($urandom); r[0] = 1'b0;
        send_byte(1'b0, r, 2);
        check("mode_cont", 64'(mode_a), 64'd0);
        check("enable_before_go", 64'(enable_a), 64'd0);
        @(negedge clk); set_rx(1'b0, 8'($urandom), 1'b1);
        @(negedge clk); set_rx(1'b0, 8'h00, 1'b0);
        check("enable_after_go", 64'(enable_a), 64'd1);
        for (int k = 0; k < 5; k++) begin
            repeat (8) @(negedge clk);
            send_byte(1'b0, 8'($urandom), 0);
            check("enable_running", 64'(enable_a), 64'd1);
        end
        @(negedge clk); halt_a = 1'b1; exp_done.push_back(cyc + 1);
        @(negedge clk);
        check("enable_after_halt", 64'(enable_a), 64'd0);
        repeat (3) @(negedge clk);
        halt_a = 1'b0;
        for (int k = 0; k < 3; k++) send_byte(1'b0, 8'($urandom) | 8'h01, 1);
        check("enable_finished", 64'(enable_a), 64'd0);
        check("load_done_finished", 64'(ld_a), 64'd1);
        check("pending_done_cont", 64'(exp_done.size()), 64'd0);

        // Step mode.
        reset_dut(1'b0);
        send_word(1'b0, rand_word());
        send_word(1'b0, TERM); check_status(1'b0);
        r = 8'($urandom); r[0] = 1'b1;
        send_byte(1'b0, r, 2);
        check("mode_step", 64'(mode_a), 64'd1);
        step_byte(8'h01, 1'b1);
        step_byte(8'h00, 1'b1);
        step_byte(8'h01, 1'b1);
        for (int k = 0; k < 4; k++) step_byte(8'($urandom), 1'b1);
        check("pending_steps", 64'(exp_step.size()), 64'd0);

        // Halt coincident with a step byte: halt wins.
        @(negedge clk); set_rx(1'b0, 8'h01, 1'b1); halt_a = 1'b1;
        exp_done.push_back(cyc + 1);
        @(negedge clk); set_rx(1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        halt_a = 1'b0;
        step_byte(8'h01, 1'b0);
        step_byte(8'h03, 1'b0);
        check("load_done_step_end", 64'(ld_a), 64'd1);
        check("mode_step_kept", 64'(mode_a), 64'd1);

        // Small memory: 5 words into 4 slots, then terminator.
        for (int i = 0; i < 5; i++) begin
            send_word(1'b1, rand_word());
            check_status(1'b1);
        end
        send_word(1'b1, TERM);
        check_status(1'b1);
        check("addr_no_wrap_b", 64'(addr_b), 64'd3);

        repeat (3) @(negedge clk);
        check("pending_wr_a", 64'(exp_wr_a.size()), 64'd0);
        check("pending_wr_b", 64'(exp_wr_b.size()), 64'd0);
        check("pending_done", 64'(exp_done.size()), 64'd0);
        check("pending_step_end", 64'(exp_step.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
